// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines x 128 bits, 10-bit byte
// address, 6-bit block address toward instruction memory. Hits return the
// selected 32-bit word combinationally; misses stall the CPU and refill the
// whole line from memory through a level-held read handshake.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// S_IDLE     | serving hits; a read miss latches the block and starts a refill
// S_MEM_READ | mem_read held high until memory drops mem_busywait; line written
// S_UPDATE   | one settle cycle after the refill before hits resume
module instruction_cache (
    input  logic         clock,
    input  logic         reset,
    input  logic         read,
    input  logic [9:0]   address,
    output logic [31:0]  instruction,
    output logic         busywait,
    output logic         mem_read,
    output logic [5:0]   mem_address,
    input  logic [127:0] mem_readinst,
    input  logic         mem_busywait
);

    localparam int LINES = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MEM_READ = 2'd1,
        S_UPDATE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [5:0]   miss_block_q, miss_block_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [2:0]   tag_q  [LINES];
    logic [2:0]   tag_d  [LINES];
    logic [127:0] data_q [LINES];
    logic [127:0] data_d [LINES];

    logic [1:0]   addr_word;
    logic [2:0]   addr_index;
    logic [2:0]   addr_tag;
    logic         hit;
    logic [127:0] line_data;
    logic         refill;
    logic         fsm_busy;
    logic         unused_byte_offset;

    // The two byte-offset bits never matter for word-aligned fetches.
    assign unused_byte_offset = ^address[1:0];

    // Address decode, hit detection and word select for the current fetch.
    always_comb begin
        addr_word   = address[3:2];
        addr_index  = address[6:4];
        addr_tag    = address[9:7];
        line_data   = data_q[addr_index];
        hit         = valid_q[addr_index] && (tag_q[addr_index] == addr_tag);
        instruction = 32'h0;
        if (read && hit) begin
            instruction = line_data[{addr_word, 5'b00000} +: 32];
        end
    end

    // Next-state and handshake outputs; mem_address always follows the
    // latched miss block so a CPU that drops its hold cannot redirect a refill.
    always_comb begin
        state_d      = state_q;
        miss_block_d = miss_block_q;
        fsm_busy     = 1'b0;
        mem_read     = 1'b0;
        refill       = 1'b0;
        mem_address  = miss_block_q;
        unique case (state_q)
            S_IDLE: begin
                fsm_busy = read && !hit;
                if (read && !hit) begin
                    miss_block_d = address[9:4];
                    state_d      = S_MEM_READ;
                end
            end
            S_MEM_READ: begin
                fsm_busy = 1'b1;
                mem_read = 1'b1;
                if (!mem_busywait) begin
                    refill  = 1'b1;
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                fsm_busy = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Stall is forced low while reset is held, even though the decode would
    // otherwise see an all-invalid cache and report a miss.
    assign busywait = reset && fsm_busy;

    // Line update on the capture edge: data, tag and valid written together.
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        if (refill) begin
            valid_d[miss_block_q[2:0]] = 1'b1;
            tag_d[miss_block_q[2:0]]   = miss_block_q[5:3];
            data_d[miss_block_q[2:0]]  = mem_readinst;
        end
    end

    // Control state and valid bits; reset abandons any refill in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            miss_block_q <= 6'h00;
            valid_q      <= '0;
        end else begin
            state_q      <= state_d;
            miss_block_q <= miss_block_d;
            valid_q      <= valid_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their visibility.
    always_ff @(posedge clock) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a behavioural cache model, a
// latency-programmable instruction memory, and per-cycle output comparison.
module tb_instruction_cache;

    logic         clock = 1'b0;
    logic         reset;
    logic         rd;
    logic [9:0]   addr;
    logic [31:0]  instruction;
    logic         busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readinst;
    logic         mem_busywait;

    int           lat = 1;
    int           rd_cnt = 0;
    logic [127:0] mem_blk [64];

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    // model state
    bit           m_valid [8];
    logic [2:0]   m_tag   [8];
    logic [127:0] m_data  [8];
    bit           pend = 1'b0;
    int           pend_e = 0;
    int           pend_m = 0;
    logic [5:0]   pend_blk = 6'h00;

    always #5 clock = ~clock;

    instruction_cache dut (
        .clock        (clock),
        .reset        (reset),
        .read         (rd),
        .address      (addr),
        .instruction  (instruction),
        .busywait     (busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readinst (mem_readinst),
        .mem_busywait (mem_busywait)
    );

    // Memory: busy for the first lat-1 cycles of a request, ready on cycle lat.
    // Garbage is driven while busy so an early capture shows up as bad data.
    always @(posedge clock) rd_cnt <= mem_read ? rd_cnt + 1 : 0;
    assign mem_busywait = mem_read && (rd_cnt < lat - 1);
    assign mem_readinst = mem_busywait ? {4{32'hDEADBEEF}} : mem_blk[mem_address];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit m_hit(input logic [9:0] a);
        return m_valid[a[6:4]] && (m_tag[a[6:4]] == a[9:7]);
    endfunction

    function automatic logic [31:0] m_word(input logic [9:0] a);
        logic [127:0] l;
        l = m_data[a[6:4]];
        return l[32*a[3:2] +: 32];
    endfunction

    // Model: a miss stalls for M+2 cycles; the line appears after M memory cycles.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            pend = 1'b0;
        end else if (pend) begin
            if (pend_e == pend_m) begin
                m_valid[pend_blk[2:0]] = 1'b1;
                m_tag[pend_blk[2:0]]   = pend_blk[5:3];
                m_data[pend_blk[2:0]]  = mem_blk[pend_blk];
            end
            if (pend_e == pend_m + 1) pend = 1'b0;
            else pend_e = pend_e + 1;
        end else if (rd && !m_hit(addr)) begin
            pend     = 1'b1;
            pend_blk = addr[9:4];
            pend_e   = 1;
            pend_m   = lat;
        end
    end

    // Per-cycle comparison against the model, mid-cycle.
    always @(negedge clock) begin
        if (reset && cmp_en) begin
            logic        e_busy;
            logic        e_mr;
            logic [31:0] e_ins;
            e_ins  = (rd && m_hit(addr)) ? m_word(addr) : 32'h0;
            e_busy = pend ? 1'b1 : (rd && !m_hit(addr));
            e_mr   = pend && (pend_e <= pend_m);
            chk("cyc_busywait", busywait, e_busy);
            chk("cyc_mem_read", mem_read, e_mr);
            chk("cyc_instruction", instruction, e_ins);
            if (e_mr) chk("cyc_mem_address", mem_address, pend_blk);
        end
    end

    // Present one fetch and hold it until the stall clears.
    task automatic access(input logic [9:0] a, input int m, output int busy,
                          output int mrc, output logic [5:0] ma, output bit st);
        bit prev_mr;
        @(posedge clock);
        #1;
        lat = m; rd = 1'b1; addr = a;
        busy = 0; mrc = 0; ma = 6'h00; st = 1'b1; prev_mr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (mem_read) begin
                if (mrc == 0) ma = mem_address;
                else if (mem_address != ma || !prev_mr) st = 1'b0;
                mrc++;
            end
            prev_mr = mem_read;
            if (!busywait) break;
            busy++;
        end
        if (busywait) chk("access_timeout", busywait, 1'b0);
    endtask

    initial begin
        int busy, mrc;
        logic [5:0] ma;
        bit st;

        for (int b = 0; b < 64; b++)
            for (int w = 0; w < 4; w++)
                mem_blk[b][32*w +: 32] = {16'hA5A5, 8'(b), 8'(w)};
        mem_blk[0] = 128'h33333333_22222222_11111111_00000000;

        reset = 1'b0; rd = 1'b0; addr = 10'h000;
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        cmp_en = 1'b1;

        // 1: cold access after reset, then a mid-cycle reset pulse
        @(posedge clock);
        #1 rd = 1'b1; addr = 10'h000; lat = 3;
        @(negedge clock);
        chk("t1_miss_busywait", busywait, 1'b1);
        chk("t1_mem_read_before_edge", mem_read, 1'b0);
        @(posedge clock);
        #1;
        chk("t1_mem_read", mem_read, 1'b1);
        chk("t1_mem_address", mem_address, 6'h00);
        #1 reset = 1'b0;
        #1;
        chk("t1_rst_busywait", busywait, 1'b0);
        chk("t1_rst_mem_read", mem_read, 1'b0);
        chk("t1_rst_mem_address", mem_address, 6'h00);
        chk("t1_rst_instruction", instruction, 32'h0);
        rd = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;

        // 2: cold miss with M=5, then a same-line hit
        access(10'h008, 5, busy, mrc, ma, st);
        chk("t2_busy_cycles", busy, 7);
        chk("t2_mem_read_cycles", mrc, 5);
        chk("t2_instruction", instruction, 32'h22222222);
        access(10'h00C, 5, busy, mrc, ma, st);
        chk("t2_hit_busy", busy, 0);
        chk("t2_hit_instruction", instruction, 32'h33333333);

        // 3: conflict eviction at index 0
        access(10'h004, 2, busy, mrc, ma, st);
        chk("t3_hit_busy", busy, 0);
        chk("t3_hit_instruction", instruction, 32'h11111111);
        access(10'h080, 2, busy, mrc, ma, st);
        chk("t3_evict_busy", busy, 4);
        chk("t3_evict_mem_address", ma, 6'h08);
        chk("t3_evict_instruction", instruction, 32'hA5A50800);
        access(10'h008, 2, busy, mrc, ma, st);
        chk("t3_remiss_busy", busy, 4);
        chk("t3_remiss_instruction", instruction, 32'h22222222);

        // 4: memory busy for 20 cycles
        access(10'h104, 21, busy, mrc, ma, st);
        chk("t4_busy_cycles", busy, 23);
        chk("t4_mem_read_cycles", mrc, 21);
        chk("t4_mem_read_steady", st, 1'b1);
        chk("t4_mem_address", ma, 6'h10);
        chk("t4_instruction", instruction, 32'hA5A51001);

        // 5: reset during MEM_READ
        @(posedge clock);
        #1 rd = 1'b1; addr = 10'h3F8; lat = 10;
        repeat (3) @(posedge clock);
        #1;
        chk("t5_mem_read_pre", mem_read, 1'b1);
        chk("t5_mem_address_pre", mem_address, 6'h3F);
        #1 reset = 1'b0;
        #1;
        chk("t5_rst_mem_read", mem_read, 1'b0);
        chk("t5_rst_busywait", busywait, 1'b0);
        chk("t5_rst_mem_address", mem_address, 6'h00);
        rd = 1'b0;
        @(posedge clock);
        #3 reset = 1'b1;
        access(10'h3F8, 2, busy, mrc, ma, st);
        chk("t5_remiss_busy", busy, 4);
        chk("t5_remiss_instruction", instruction, 32'hA5A53F02);

        // 6: no read on an uncached address, then on a cached one
        @(posedge clock);
        #1 rd = 1'b0; addr = 10'h3C4;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("t6_busywait", busywait, 1'b0);
            chk("t6_mem_read", mem_read, 1'b0);
            chk("t6_instruction", instruction, 32'h0);
        end
        #1 addr = 10'h3FC;
        @(negedge clock);
        chk("t6_cached_no_read", instruction, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
